// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues word fetches over req/ack and buffers {pc, instr} for decode.
// Optional statistics counters (stat_fetch_cnt, stat_flush_cnt) are built when PREFETCH_STATS_EN is defined.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  fsm_state
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_flush_cnt
`endif
);

    // Handshakes: imem side holds req/addr until ack (ack is a no-op while req=0);
    // decode side transfers the head when inst_valid && inst_ready on a rising edge.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   drop_addr, drop_addr_next;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          credit, accepted, push, pop;

    // No request is ever outstanding in IDLE, so credit reduces to count < DEPTH.
    assign credit     = (count < CW'(DEPTH));
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign fsm_state  = state;

    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_addr_next = drop_addr;
        imem_req       = 1'b0;
        imem_addr      = fetch_pc;
        case (state)
            IDLE:    imem_req = credit && !redirect_valid;
            WAIT:    imem_req = 1'b1;
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
            end
            default: imem_req = 1'b0;
        endcase
        // Reset drops the request combinationally; memory side tolerates it.
        imem_req   = imem_req && reset;
        pop        = inst_valid && inst_ready && !redirect_valid;
        accepted   = imem_req && imem_ack;
        push       = accepted && (state != DROP) && !redirect_valid;
        count_next = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~32'h3;
            if (imem_req && !imem_ack) begin
                // Handshake in flight: keep it alive at the old address and discard its data.
                state_next = DROP;
                if (state == WAIT) drop_addr_next = fetch_pc;
            end else begin
                state_next = IDLE;
            end
        end else if (state == DROP) begin
            if (imem_ack) state_next = IDLE;
        end else if (push) begin
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = (count_next < CW'(DEPTH)) ? WAIT : IDLE;
        end else if (imem_req) begin
            state_next = WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            drop_addr <= drop_addr_next;
            count     <= count_next;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetch_cnt <= 32'h0;
            stat_flush_cnt <= 32'h0;
        end else begin
            if (push)           stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (redirect_valid) stat_flush_cnt <= stat_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: memory responder, {pc,data} scoreboard, scenario tasks.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, redirect_pc;
    logic [1:0]  fsm_state;

    logic        hi_req, hi_valid, hi_ack_en;
    logic [31:0] hi_addr, hi_data, hi_pc;
    logic [1:0]  hi_state;
    logic        hi_ack;
    logic [31:0] hi_rdata;

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetch_cnt, stat_flush_cnt, hi_fetch_cnt, hi_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fsm_state(fsm_state)
`ifdef PREFETCH_STATS_EN
        , .stat_fetch_cnt(stat_fetch_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
    );

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(hi_ack), .imem_rdata(hi_rdata),
        .inst_valid(hi_valid), .inst_ready(1'b1), .inst_data(hi_data), .inst_pc(hi_pc),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .fsm_state(hi_state)
`ifdef PREFETCH_STATS_EN
        , .stat_fetch_cnt(hi_fetch_cnt), .stat_flush_cnt(hi_flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign hi_ack   = hi_req && hi_ack_en;
    assign hi_rdata = mem_word(hi_addr);

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr, drop_addr_m, exp_req_addr;
    bit          discard_pending;

    logic        o_req, o_valid, acked, popped, extra;
    logic [31:0] o_addr, o_pc, o_data;
    logic [63:0] pop_exp;

    task automatic model_clear();
        exp_q.delete();
        exp_addr        = 32'h0;
        drop_addr_m     = 32'h0;
        discard_pending = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        hi_ack_en      = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: drive inputs, answer the fetch, update the scoreboard model.
    task automatic step(input bit ack_en, input bit ready, input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ack       = 1'b0;
        #1;
        o_req        = imem_req;
        o_addr       = imem_addr;
        o_valid      = inst_valid;
        o_pc         = inst_pc;
        o_data       = inst_data;
        exp_req_addr = discard_pending ? drop_addr_m : exp_addr;
        acked        = ack_en && o_req;
        imem_ack     = acked;
        imem_rdata   = mem_word(o_addr);
        popped       = 1'b0;
        extra        = 1'b0;
        if (o_valid && ready && !redir) begin
            if (exp_q.size() > 0) begin
                pop_exp = exp_q.pop_front();
                popped  = 1'b1;
            end else begin
                extra = 1'b1;
            end
        end
        if (redir) begin
            exp_q.delete();
            if (o_req && !acked) begin
                if (!discard_pending) drop_addr_m = exp_addr;
                discard_pending = 1;
            end else begin
                discard_pending = 0;
            end
            exp_addr = rpc & ~32'h3;
        end else if (acked) begin
            if (discard_pending) begin
                discard_pending = 0;
            end else begin
                exp_q.push_back({exp_addr, mem_word(exp_addr)});
                exp_addr = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        cmp_cnt++; if (imem_req !== 1'b0)        begin err_cnt++; $display("FAIL reset_req: got %b want 0", imem_req); end
        cmp_cnt++; if (imem_addr !== 32'h0)      begin err_cnt++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        cmp_cnt++; if (inst_valid !== 1'b0)      begin err_cnt++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        cmp_cnt++; if (inst_data !== 32'h0)      begin err_cnt++; $display("FAIL reset_data: got %h want 0", inst_data); end
        cmp_cnt++; if (inst_pc !== 32'h0)        begin err_cnt++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        cmp_cnt++; if (fsm_state !== 2'd0)       begin err_cnt++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        cmp_cnt++; if (hi_addr !== 32'hFFFF_FFF8) begin err_cnt++; $display("FAIL reset_hi_addr: got %h want fffffff8", hi_addr); end
    endtask

    task automatic test_stream();
        int pops = 0;
        int reqs = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 32'h0);
            if (o_req) begin
                reqs++;
                cmp_cnt++;
                if (o_addr !== exp_req_addr) begin err_cnt++; $display("FAIL stream_addr: got %h want %h", o_addr, exp_req_addr); end
            end
            if (popped) begin
                pops++;
                cmp_cnt++;
                if ({o_pc, o_data} !== pop_exp) begin err_cnt++; $display("FAIL stream_entry: got %h/%h want %h/%h", o_pc, o_data, pop_exp[63:32], pop_exp[31:0]); end
            end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL stream_extra: got pc %h want no entry", o_pc); end
        end
        cmp_cnt++; if (reqs != 12) begin err_cnt++; $display("FAIL stream_reqs: got %0d want 12", reqs); end
        cmp_cnt++; if (pops != 11) begin err_cnt++; $display("FAIL stream_pops: got %0d want 11", pops); end
    endtask

    task automatic test_backpressure();
        int acks = 0;
        int pops = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 32'h0);
            if (acked) begin
                acks++;
                cmp_cnt++;
                if (o_addr !== exp_req_addr) begin err_cnt++; $display("FAIL bp_addr: got %h want %h", o_addr, exp_req_addr); end
            end
        end
        cmp_cnt++; if (acks != 4)              begin err_cnt++; $display("FAIL bp_requests: got %0d want 4", acks); end
        cmp_cnt++; if (o_req !== 1'b0)         begin err_cnt++; $display("FAIL bp_req_low: got %b want 0", o_req); end
        cmp_cnt++; if (o_valid !== 1'b1)       begin err_cnt++; $display("FAIL bp_valid: got %b want 1", o_valid); end
        cmp_cnt++; if (o_pc !== 32'h0)         begin err_cnt++; $display("FAIL bp_head_pc: got %h want 0", o_pc); end
        cmp_cnt++; if (o_data !== mem_word(32'h0)) begin err_cnt++; $display("FAIL bp_head_data: got %h want %h", o_data, mem_word(32'h0)); end
        // Drain with fetch running: exercises push and pop in the same cycle at high occupancy.
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 32'h0);
            if (o_req) begin
                cmp_cnt++;
                if (o_addr !== exp_req_addr) begin err_cnt++; $display("FAIL drain_addr: got %h want %h", o_addr, exp_req_addr); end
            end
            if (popped) begin
                pops++;
                cmp_cnt++;
                if ({o_pc, o_data} !== pop_exp) begin err_cnt++; $display("FAIL drain_entry: got %h/%h want %h/%h", o_pc, o_data, pop_exp[63:32], pop_exp[31:0]); end
            end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL drain_extra: got pc %h want no entry", o_pc); end
        end
        cmp_cnt++; if (pops != 12) begin err_cnt++; $display("FAIL drain_pops: got %0d want 12", pops); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h0000_0103);
        cmp_cnt++; if (o_valid !== 1'b1) begin err_cnt++; $display("FAIL flush_pre_valid: got %b want 1", o_valid); end
        step(0, 0, 0, 32'h0);
        cmp_cnt++; if (o_valid !== 1'b0)        begin err_cnt++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        cmp_cnt++; if (o_req !== 1'b1)          begin err_cnt++; $display("FAIL flush_req: got %b want 1", o_req); end
        cmp_cnt++; if (o_addr !== 32'h0000_0100) begin err_cnt++; $display("FAIL flush_addr: got %h want 00000100", o_addr); end
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 32'h0);
            if (o_req) begin
                cmp_cnt++;
                if (o_addr !== exp_req_addr) begin err_cnt++; $display("FAIL flush_run_addr: got %h want %h", o_addr, exp_req_addr); end
            end
            if (popped) begin
                cmp_cnt++;
                if ({o_pc, o_data} !== pop_exp) begin err_cnt++; $display("FAIL flush_run_entry: got %h/%h want %h/%h", o_pc, o_data, pop_exp[63:32], pop_exp[31:0]); end
            end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL flush_run_extra: got pc %h want no entry", o_pc); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0000_0200);
        cmp_cnt++; if (o_addr !== 32'h8) begin err_cnt++; $display("FAIL drop_orig_addr: got %h want 00000008", o_addr); end
        for (int i = 0; i < 3; i++) begin
            // Second redirect while the dropped handshake is still open only moves fetch_pc.
            step(i == 2, 1, i == 1, 32'h0000_0207);
            cmp_cnt++; if (o_req !== 1'b1)       begin err_cnt++; $display("FAIL drop_req_held: got %b want 1", o_req); end
            cmp_cnt++; if (o_addr !== 32'h8)     begin err_cnt++; $display("FAIL drop_addr_held: got %h want 00000008", o_addr); end
            cmp_cnt++; if (o_valid !== 1'b0)     begin err_cnt++; $display("FAIL drop_valid: got %b want 0", o_valid); end
        end
        step(1, 1, 0, 32'h0);
        cmp_cnt++; if (o_valid !== 1'b0)         begin err_cnt++; $display("FAIL drop_no_push: got %b want 0", o_valid); end
        cmp_cnt++; if (o_req !== 1'b1)           begin err_cnt++; $display("FAIL drop_new_req: got %b want 1", o_req); end
        cmp_cnt++; if (o_addr !== 32'h0000_0204) begin err_cnt++; $display("FAIL drop_new_addr: got %h want 00000204", o_addr); end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 32'h0);
            if (popped) begin
                cmp_cnt++;
                if ({o_pc, o_data} !== pop_exp) begin err_cnt++; $display("FAIL drop_run_entry: got %h/%h want %h/%h", o_pc, o_data, pop_exp[63:32], pop_exp[31:0]); end
            end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL drop_run_extra: got pc %h want no entry", o_pc); end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 32'h0);
            want = 32'hFFFF_FFF8 + 32'(4 * i);
            cmp_cnt++; if (hi_req !== 1'b1) begin err_cnt++; $display("FAIL wrap_req: got %b want 1", hi_req); end
            cmp_cnt++; if (hi_addr !== want) begin err_cnt++; $display("FAIL wrap_addr: got %h want %h", hi_addr, want); end
            if (i > 0) begin
                want = want - 32'd4;
                cmp_cnt++;
                if ({hi_valid, hi_pc, hi_data} !== {1'b1, want, mem_word(want)}) begin
                    err_cnt++; $display("FAIL wrap_entry: got %b/%h/%h want 1/%h/%h", hi_valid, hi_pc, hi_data, want, mem_word(want));
                end
            end
            hi_ack_en = 1'b1;
        end
        hi_ack_en = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        cmp_cnt++; if (o_req !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_req: got %b want 1", o_req); end
        #1;
        reset = 1'b0;
        #1;
        cmp_cnt++; if (imem_req !== 1'b0)   begin err_cnt++; $display("FAIL mid_req: got %b want 0", imem_req); end
        cmp_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
        cmp_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_valid: got %b want 0", inst_valid); end
        cmp_cnt++; if (inst_pc !== 32'h0)   begin err_cnt++; $display("FAIL mid_pc: got %h want 0", inst_pc); end
        cmp_cnt++; if (inst_data !== 32'h0) begin err_cnt++; $display("FAIL mid_data: got %h want 0", inst_data); end
        imem_ack = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        // Decode ready on an empty queue must not disturb anything.
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 32'h0);
            cmp_cnt++; if (o_valid !== 1'b0)  begin err_cnt++; $display("FAIL restart_valid: got %b want 0", o_valid); end
            cmp_cnt++; if (o_addr !== 32'h0)  begin err_cnt++; $display("FAIL restart_addr: got %h want 0", o_addr); end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL restart_extra: got pc %h want no entry", o_pc); end
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 32'h0);
            if (o_req) begin
                cmp_cnt++;
                if (o_addr !== exp_req_addr) begin err_cnt++; $display("FAIL restart_run_addr: got %h want %h", o_addr, exp_req_addr); end
            end
            if (popped) begin
                cmp_cnt++;
                if ({o_pc, o_data} !== pop_exp) begin err_cnt++; $display("FAIL restart_entry: got %h/%h want %h/%h", o_pc, o_data, pop_exp[63:32], pop_exp[31:0]); end
            end
            if (extra) begin cmp_cnt++; err_cnt++; $display("FAIL restart_run_extra: got pc %h want no entry", o_pc); end
        end
    endtask

    initial begin
        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        hi_ack_en      = 1'b0;
        model_clear();
        #12;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_drop();
        test_pc_wrap();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
